// File: rtl/ntt_pkg.sv
// Shared types and index helpers for the NTT address sequencer.
// Helpers are plain integer functions so the top can size results to LOGN bits.
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Butterfly span: shrinks per stage for forward (CT), grows for inverse (GS).
  function automatic logic [31:0] half_len(input logic [31:0] logn, input logic [31:0] s,
                                           input logic inv);
    return inv ? (32'd1 << s) : ((32'd1 << logn) >> (s + 32'd1));
  endfunction

  function automatic logic [31:0] tw_index(input logic [31:0] logn, input logic [31:0] s,
                                           input logic [31:0] g, input logic inv);
    return inv ? (((32'd1 << logn) >> s) - 32'd1 - g) : ((32'd1 << s) + g);
  endfunction

endpackage

// File: rtl/ntt_addr_delay.sv
// Enable-gated shift register carrying {valid, A, B} from read issue to write-back.
// Freezes entirely while en is low so latency is counted in unstalled cycles.
module ntt_addr_delay #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else if (en) begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_address_sequencer.sv
// Read/twiddle/write-back address sequencer for an in-place radix-2 NTT/INTT.
// Handshake: start is taken only in IDLE with stall low; stall freezes every register.
module ntt_address_sequencer
  import ntt_pkg::*;
#(
  parameter int LOGN     = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            inverse,
  input  logic            stall,
  output logic [LOGN-1:0] rdAddrA,
  output logic [LOGN-1:0] rdAddrB,
  output logic [LOGN-1:0] twAddr,
  output logic            rdValid,
  output logic [LOGN-1:0] wrAddrA,
  output logic [LOGN-1:0] wrAddrB,
  output logic            wrValid,
  output logic            busy,
  output logic            done,
  output logic [1:0]      dbg_state
);

  localparam int KW = LOGN - 1;
  localparam int SW = $clog2(LOGN + 1);
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int DLW = 1 + 2 * LOGN;

  state_t          state;
  logic [KW-1:0]   k;
  logic [SW-1:0]   s;
  logic [DW-1:0]   dcnt;
  logic            inv_q;

  logic [KW-1:0]   sel_k;
  logic [SW-1:0]   sel_s;
  logic            sel_inv;
  logic [31:0]     half;
  logic [31:0]     grp;
  logic [31:0]     a_full;
  logic [31:0]     tw_full;
  logic [LOGN-1:0] next_a;
  logic [LOGN-1:0] next_b;
  logic [LOGN-1:0] next_tw;

  // Address of the butterfly that will be presented after the coming edge.
  always_comb begin
    sel_k   = '0;
    sel_s   = '0;
    sel_inv = inv_q;
    case (state)
      IDLE:    sel_inv = inverse;
      ISSUE: begin
        sel_k = k + 1'b1;
        sel_s = s;
      end
      DRAIN:   sel_s = s;
      default: ;
    endcase
    half    = half_len(32'(LOGN), 32'(sel_s), sel_inv);
    grp     = sel_inv ? (32'(sel_k) >> sel_s)
                      : (32'(sel_k) >> (32'(LOGN) - 32'd1 - 32'(sel_s)));
    a_full  = 32'd2 * half * grp + (32'(sel_k) & (half - 32'd1));
    tw_full = tw_index(32'(LOGN), 32'(sel_s), grp, sel_inv);
    next_a  = LOGN'(a_full);
    next_b  = LOGN'(a_full + half);
    next_tw = LOGN'(tw_full);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      k       <= '0;
      s       <= '0;
      dcnt    <= '0;
      inv_q   <= 1'b0;
      rdAddrA <= '0;
      rdAddrB <= '0;
      twAddr  <= '0;
      rdValid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (!stall) begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ISSUE;
            inv_q   <= inverse;
            k       <= '0;
            s       <= '0;
            busy    <= 1'b1;
            rdValid <= 1'b1;
            rdAddrA <= next_a;
            rdAddrB <= next_b;
            twAddr  <= next_tw;
          end
        end
        ISSUE: begin
          if (k == '1) begin
            state   <= DRAIN;
            k       <= '0;
            s       <= s + 1'b1;
            dcnt    <= '0;
            rdValid <= 1'b0;
            rdAddrA <= '0;
            rdAddrB <= '0;
            twAddr  <= '0;
          end else begin
            k       <= k + 1'b1;
            rdAddrA <= next_a;
            rdAddrB <= next_b;
            twAddr  <= next_tw;
          end
        end
        DRAIN: begin
          // s already points at the next stage; s == LOGN means all stages issued.
          if (dcnt == DW'(PIPE_LAT - 1)) begin
            if (s == SW'(LOGN)) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= ISSUE;
              rdValid <= 1'b1;
              rdAddrA <= next_a;
              rdAddrB <= next_b;
              twAddr  <= next_tw;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [DLW-1:0] dl_out;

  ntt_addr_delay #(
    .WIDTH (DLW),
    .DEPTH (PIPE_LAT)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (~stall),
    .din  ({rdValid, rdAddrA, rdAddrB}),
    .dout (dl_out)
  );

  assign wrValid   = dl_out[DLW-1];
  assign wrAddrA   = dl_out[2*LOGN-1:LOGN];
  assign wrAddrB   = dl_out[LOGN-1:0];
  assign dbg_state = state;

endmodule

// File: tb/tb_ntt_address_sequencer.sv
// Bench for ntt_address_sequencer: a small (N=8) and a large (N=256) instance share stimulus;
// one monitor checks the selected instance against a queue filled from a butterfly-pair model.
module tb_ntt_address_sequencer;

  logic clk, rst, start, inverse, stall;
  logic sel_big;
  int   stall_pct;

  logic [2:0] s_ra, s_rb, s_tw, s_wa, s_wb;
  logic       s_rv, s_wv, s_busy, s_done;
  logic [1:0] s_dbg;
  logic [7:0] b_ra, b_rb, b_tw, b_wa, b_wb;
  logic       b_rv, b_wv, b_busy, b_done;
  logic [1:0] b_dbg;

  ntt_address_sequencer #(.LOGN(3), .PIPE_LAT(2)) u_small (
    .clk(clk), .rst(rst), .start(start & ~sel_big), .inverse(inverse), .stall(stall),
    .rdAddrA(s_ra), .rdAddrB(s_rb), .twAddr(s_tw), .rdValid(s_rv),
    .wrAddrA(s_wa), .wrAddrB(s_wb), .wrValid(s_wv), .busy(s_busy), .done(s_done),
    .dbg_state(s_dbg)
  );

  ntt_address_sequencer #(.LOGN(8), .PIPE_LAT(4)) u_big (
    .clk(clk), .rst(rst), .start(start & sel_big), .inverse(inverse), .stall(stall),
    .rdAddrA(b_ra), .rdAddrB(b_rb), .twAddr(b_tw), .rdValid(b_rv),
    .wrAddrA(b_wa), .wrAddrB(b_wb), .wrValid(b_wv), .busy(b_busy), .done(b_done),
    .dbg_state(b_dbg)
  );

  logic [7:0] m_a, m_b, m_tw, m_wa, m_wb;
  logic       m_rdv, m_wrv, m_busy, m_done;
  assign m_a    = sel_big ? b_ra   : {5'b0, s_ra};
  assign m_b    = sel_big ? b_rb   : {5'b0, s_rb};
  assign m_tw   = sel_big ? b_tw   : {5'b0, s_tw};
  assign m_wa   = sel_big ? b_wa   : {5'b0, s_wa};
  assign m_wb   = sel_big ? b_wb   : {5'b0, s_wb};
  assign m_rdv  = sel_big ? b_rv   : s_rv;
  assign m_wrv  = sel_big ? b_wv   : s_wv;
  assign m_busy = sel_big ? b_busy : s_busy;
  assign m_done = sel_big ? b_done : s_done;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      stall = (stall_pct > 0) && (int'($urandom_range(99)) < stall_pct);
    end
  end

  // scoreboard state
  logic [23:0] rd_q[$];
  logic [15:0] wr_q[$];
  int          hist_q[$];
  int          n_vec = 0, n_err = 0;
  int          logn, pl, n, hn;
  int          rd_idx, wr_cnt, busy_cyc, stall_busy, done_cnt, ucyc;
  int          addr_cnt[256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: stage s pairs every address a whose half-bit is clear with a+half, ascending a.
  task automatic push_expected(input int lg, input bit inv);
    int nn, half, tw;
    nn = 1 << lg;
    for (int s = 0; s < lg; s++) begin
      half = inv ? (1 << s) : (nn >> (s + 1));
      for (int a = 0; a < nn; a++) begin
        if ((a & half) == 0) begin
          tw = inv ? ((nn >> s) - 1 - a / (2 * half)) : ((1 << s) + a / (2 * half));
          rd_q.push_back({8'(a), 8'(a + half), 8'(tw)});
          wr_q.push_back({8'(a), 8'(a + half)});
        end
      end
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [23:0] e;
    logic [15:0] w;
    int t;
    if (rst) begin
      if (m_rdv && !stall) begin
        check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) begin
          e = rd_q.pop_front();
          check("rd_pair_tw", {8'd0, m_a, m_b, m_tw}, {8'd0, e});
        end
        if (rd_idx >= hn)
          check("rd_after_drain", 32'(wr_cnt >= (rd_idx / hn) * hn), 32'd1);
        check("tw_nonzero", 32'(m_tw != 8'd0), 32'd1);
        rd_idx++;
        hist_q.push_back(ucyc);
      end
      if (!m_rdv) check("rd_idle_zero", {8'd0, m_a, m_b, m_tw}, 32'd0);
      if (m_wrv && !stall) begin
        check("wr_expected", 32'(wr_q.size() != 0 && hist_q.size() != 0), 32'd1);
        if (wr_q.size() != 0 && hist_q.size() != 0) begin
          w = wr_q.pop_front();
          check("wr_pair", {16'd0, m_wa, m_wb}, {16'd0, w});
          t = hist_q.pop_front();
          check("wr_latency", 32'(ucyc - t), 32'(pl));
        end
        wr_cnt++;
        addr_cnt[m_wa]++;
        addr_cnt[m_wb]++;
      end
      if (!m_wrv) check("wr_idle_zero", {16'd0, m_wa, m_wb}, 32'd0);
      if (m_busy) begin
        busy_cyc++;
        if (stall) stall_busy++;
      end
      if (m_done && !stall) begin
        done_cnt++;
        t = 0;
        for (int i = 0; i < n; i++) if (addr_cnt[i] != logn) t++;
        check("done_busy_low", 32'(m_busy), 32'd0);
        check("busy_length", 32'(busy_cyc), 32'(logn * (hn + pl) + stall_busy));
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("addr_once_per_stage", 32'(t), 32'd0);
      end
      if (!stall) ucyc++;
    end
  end

  // driver tasks
  task automatic begin_run(input bit big, input bit inv, input int spct);
    int t;
    sel_big = big;
    logn = big ? 8 : 3;
    pl   = big ? 4 : 2;
    n    = 1 << logn;
    hn   = n / 2;
    rd_idx = 0; wr_cnt = 0; busy_cyc = 0; stall_busy = 0; done_cnt = 0;
    rd_q.delete(); wr_q.delete(); hist_q.delete();
    for (int i = 0; i < 256; i++) addr_cnt[i] = 0;
    push_expected(logn, inv);
    stall_pct = spct;
    inverse = inv;
    start = 1'b1;
    t = 0;
    while (!m_busy && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("start_accepted", 32'(m_busy), 32'd1);
  endtask

  task automatic run(input bit big, input bit inv, input int spct, input bit churn);
    int t;
    begin_run(big, inv, spct);
    if (!churn) start = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 6000) begin
      @(posedge clk);
      #1;
      t++;
      if (done_cnt != 0) break;
      if (churn) begin
        start   = 1'($urandom_range(1));
        inverse = 1'($urandom_range(1));
      end
    end
    start = 1'b0;
    stall_pct = 0;
    check("done_seen", 32'(done_cnt), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("single_done", 32'(done_cnt), 32'd1);
    check("no_restart", 32'(m_busy), 32'd0);
  endtask

  task automatic abort_run();
    int t;
    begin_run(1'b0, 1'b0, 0);
    start = 1'b0;
    t = 0;
    while (rd_idx <= hn + 1 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("reached_stage1", 32'(rd_idx > hn + 1), 32'd1);
    rst = 1'b0;
    rd_q.delete(); wr_q.delete(); hist_q.delete();
    @(negedge clk);
    check("abort_rd_zero", {7'd0, m_rdv, m_a, m_b, m_tw}, 32'd0);
    check("abort_wr_zero", {15'd0, m_wrv, m_wa, m_wb}, 32'd0);
    check("abort_busy_done", {30'd0, m_busy, m_done}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_abort_wrvalid", 32'(m_wrv), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; inverse = 1'b0; sel_big = 1'b0; stall_pct = 0;
    logn = 3; pl = 2; n = 8; hn = 4; ucyc = 0;
    rd_idx = 0; wr_cnt = 0; busy_cyc = 0; stall_busy = 0; done_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_small", {6'd0, s_rv, s_wv, s_busy, s_done, s_ra, s_rb, s_tw, s_wa, s_wb, s_dbg},
          32'd0);
    check("reset_big", {14'd0, b_rv, b_wv, b_busy, b_done, b_ra, b_rb, b_dbg}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run(1'b0, 1'b0, 0, 1'b0);
    run(1'b0, 1'b1, 0, 1'b0);
    run(1'b0, 1'b0, 30, 1'b0);
    run(1'b0, 1'b1, 30, 1'b0);
    abort_run();
    run(1'b0, 1'b0, 0, 1'b0);
    run(1'b0, 1'b1, 0, 1'b1);
    run(1'b1, 1'b0, 30, 1'b0);
    run(1'b1, 1'b1, 30, 1'b0);
    run(1'b1, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
